// File: rtl/pacman_motion_ctrl.sv
// pacman_motion_ctrl
//   Frame-paced Pac-Man movement controller. On each rising edge of
//   screenEnd it tries to step the sprite one pixel. A buffered turn
//   request is tried first and the current heading second. Each candidate
//   position is checked against the screen bounds locally and against walls
//   through an external checker using a req/ack handshake.
// Ports
//   clk, reset                 100 MHz clock, synchronous active-high reset
//   screenEnd                  frame-boundary level (rising edge used)
//   BTNU/BTND/BTNL/BTNR        raw direction buttons
//   chkAck, chkBlocked         wall-checker answer (blocked valid with ack)
//   chkReq, chkX, chkY         wall-checker query
//   pacman_x, pacman_y         committed sprite position
//   curDir                     heading 0=up 1=down 2=left 3=right
//   moving                     last frame committed a step
//   moveDone                   one-cycle pulse at end of frame processing
//   frameOverrun               one-cycle pulse when a frame edge is dropped
module pacman_motion_ctrl #(
  parameter int START_X = 310,
  parameter int START_Y = 230,
  parameter int MAX_X   = 618,
  parameter int MAX_Y   = 458
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       screenEnd,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  input  logic       chkAck,
  input  logic       chkBlocked,
  output logic       chkReq,
  output logic [9:0] chkX,
  output logic [8:0] chkY,
  output logic [9:0] pacman_x,
  output logic [8:0] pacman_y,
  output logic [1:0] curDir,
  output logic       moving,
  output logic       moveDone,
  output logic       frameOverrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_TRY_REQ, S_WAIT_REQ, S_TRY_CUR, S_WAIT_CUR, S_DONE
  } state_t;

  localparam logic [1:0] D_UP = 2'd0;
  localparam logic [1:0] D_DN = 2'd1;
  localparam logic [1:0] D_LT = 2'd2;
  localparam logic [1:0] D_RT = 2'd3;

  logic [3:0] r_btn_s1, r_btn_s2;   // {U,D,L,R}
  logic [1:0] r_reqDir;
  logic       r_reqValid;
  logic       r_scr_q;
  logic [1:0] r_tryDir;             // heading of the query in flight
  state_t     r_state;

  logic       w_tick;
  logic [1:0] w_dir;
  logic [9:0] w_cx;
  logic [8:0] w_cy;
  logic       w_ok;

  assign w_tick = screenEnd & ~r_scr_q;
  assign w_dir  = (r_state == S_TRY_REQ) ? r_reqDir : curDir;

  // Candidate one pixel away; the range test uses the current position so
  // the wrapped result of an underflow/overflow is never used.
  always_comb begin
    w_cx = pacman_x;
    w_cy = pacman_y;
    w_ok = 1'b0;
    case (w_dir)
      D_UP: begin w_cy = pacman_y - 9'd1;  w_ok = (pacman_y != 9'd0);        end
      D_DN: begin w_cy = pacman_y + 9'd1;  w_ok = (pacman_y < 9'(MAX_Y));    end
      D_LT: begin w_cx = pacman_x - 10'd1; w_ok = (pacman_x != 10'd0);       end
      default: begin w_cx = pacman_x + 10'd1; w_ok = (pacman_x < 10'(MAX_X)); end
    endcase
  end

  // Button synchronizers, turn buffer (U > D > L > R) and frame-edge register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
      r_reqDir   <= D_RT;
      r_reqValid <= 1'b0;
      r_scr_q    <= 1'b0;
    end else begin
      r_btn_s1 <= {BTNU, BTND, BTNL, BTNR};
      r_btn_s2 <= r_btn_s1;
      r_scr_q  <= screenEnd;
      if (|r_btn_s2) begin
        r_reqValid <= 1'b1;
        r_reqDir   <= r_btn_s2[3] ? D_UP :
                      r_btn_s2[2] ? D_DN :
                      r_btn_s2[1] ? D_LT : D_RT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_tryDir     <= D_RT;
      pacman_x     <= 10'(START_X);
      pacman_y     <= 9'(START_Y);
      curDir       <= D_RT;
      moving       <= 1'b0;
      chkReq       <= 1'b0;
      chkX         <= '0;
      chkY         <= '0;
      moveDone     <= 1'b0;
      frameOverrun <= 1'b0;
    end else begin
      moveDone     <= 1'b0;
      frameOverrun <= w_tick && (r_state != S_IDLE);
      case (r_state)
        S_IDLE:
          if (w_tick)
            r_state <= (r_reqValid && r_reqDir != curDir) ? S_TRY_REQ : S_TRY_CUR;
        S_TRY_REQ, S_TRY_CUR: begin
          if (w_ok) begin
            chkX     <= w_cx;
            chkY     <= w_cy;
            chkReq   <= 1'b1;
            r_tryDir <= w_dir;
            r_state  <= (r_state == S_TRY_REQ) ? S_WAIT_REQ : S_WAIT_CUR;
          end else if (r_state == S_TRY_REQ) begin
            r_state <= S_TRY_CUR;
          end else begin
            moving   <= 1'b0;
            moveDone <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_WAIT_REQ, S_WAIT_CUR:
          if (chkAck) begin
            chkReq <= 1'b0;
            if (!chkBlocked) begin
              // chkX/chkY still hold the candidate that was approved
              pacman_x <= chkX;
              pacman_y <= chkY;
              curDir   <= r_tryDir;
              moving   <= 1'b1;
              moveDone <= 1'b1;
              r_state  <= S_DONE;
            end else if (r_state == S_WAIT_REQ) begin
              r_state <= S_TRY_CUR;
            end else begin
              moving   <= 1'b0;
              moveDone <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Bench for pacman_motion_ctrl: directed scenarios followed by random frames.
// A frame-level model predicts the query sequence and the frame outcome.
module tb_pacman_motion_ctrl;

  localparam int MX = 618;
  localparam int MY = 458;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       screenEnd = 1'b0;
  logic       BTNU = 1'b0, BTND = 1'b0, BTNL = 1'b0, BTNR = 1'b0;
  logic       chkAck = 1'b0, chkBlocked = 1'b0;
  logic       chkReq;
  logic [9:0] chkX, pacman_x;
  logic [8:0] chkY, pacman_y;
  logic [1:0] curDir;
  logic       moving, moveDone, frameOverrun;

  pacman_motion_ctrl dut (
    .clk(clk), .reset(reset), .screenEnd(screenEnd),
    .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR),
    .chkAck(chkAck), .chkBlocked(chkBlocked),
    .chkReq(chkReq), .chkX(chkX), .chkY(chkY),
    .pacman_x(pacman_x), .pacman_y(pacman_y), .curDir(curDir),
    .moving(moving), .moveDone(moveDone), .frameOverrun(frameOverrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int n_done = 0, n_ovr = 0, n_commit = 0;
  int px = 310, py = 230;

  // reference model state
  int m_x, m_y, m_dir, m_rd, m_mv;
  bit m_rv;

  typedef struct { int x; int y; bit blk; } q_t;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // event counters sampled away from the active edge
  always @(negedge clk) begin
    if (moveDone) n_done++;
    if (frameOverrun) n_ovr++;
    if (pacman_x != px || pacman_y != py) n_commit++;
    px = pacman_x;
    py = pacman_y;
  end

  function automatic void step(input int d, input int x, input int y,
                               output int nx, output int ny, output bit ok);
    nx = x; ny = y; ok = 1'b0;
    case (d)
      0: begin ok = (y > 0);  ny = y - 1; end
      1: begin ok = (y < MY); ny = y + 1; end
      2: begin ok = (x > 0);  nx = x - 1; end
      default: begin ok = (x < MX); nx = x + 1; end
    endcase
  endfunction

  task automatic model_reset();
    m_x = 310; m_y = 230; m_dir = 3; m_rd = 3; m_rv = 0; m_mv = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  task automatic set_btn(input bit [3:0] b);
    {BTNU, BTND, BTNL, BTNR} = b;
    repeat (4) @(negedge clk);
    if (b != 0) begin
      m_rv = 1;
      m_rd = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
    end
  endtask

  // One frame: br/bc = checker verdict for the turn / straight query,
  // dly = cycles before ack, ovr = inject a second edge while waiting.
  task automatic frame(input bit br, input bit bc, input int dly, input bit ovr);
    q_t q[$];
    int nx, ny, cnt, ovr0;
    bit ok, done;
    done = 0;
    if (m_rv && m_rd != m_dir) begin
      step(m_rd, m_x, m_y, nx, ny, ok);
      if (ok) begin
        q.push_back('{nx, ny, br});
        if (!br) begin m_x = nx; m_y = ny; m_dir = m_rd; done = 1; end
      end
    end
    if (!done) begin
      step(m_dir, m_x, m_y, nx, ny, ok);
      if (ok) begin
        q.push_back('{nx, ny, bc});
        if (!bc) begin m_x = nx; m_y = ny; done = 1; end
      end
    end
    m_mv = done;
    ovr0 = n_ovr;

    screenEnd = 1'b1;
    @(negedge clk);
    screenEnd = 1'b0;
    foreach (q[i]) begin
      cnt = 0;
      while (!chkReq && cnt < 10) begin @(negedge clk); cnt++; end
      chk("req_up", chkReq, 1);
      chk("chkX", chkX, q[i].x);
      chk("chkY", chkY, q[i].y);
      for (int k = 0; k < dly; k++) begin
        if (ovr && i == q.size() - 1 && k == 0) screenEnd = 1'b1;
        @(negedge clk);
        screenEnd = 1'b0;
        chk("req_hold", chkReq, 1);
        chk("x_hold", chkX, q[i].x);
        chk("y_hold", chkY, q[i].y);
        chk("pos_mid", pacman_x, px);
      end
      chkAck = 1'b1;
      chkBlocked = q[i].blk;
      @(negedge clk);
      chkAck = 1'b0;
      chkBlocked = 1'($urandom_range(0, 1));
      chk("req_drop", chkReq, 0);
    end
    cnt = 0;
    while (!moveDone && cnt < 10) begin
      chk("no_req", chkReq, 0);
      @(negedge clk);
      cnt++;
    end
    chk("moveDone", moveDone, 1);
    chk("pac_x", pacman_x, m_x);
    chk("pac_y", pacman_y, m_y);
    chk("curDir", curDir, m_dir);
    chk("moving", moving, m_mv);
    @(negedge clk);
    chk("md_pulse", moveDone, 0);
    chk("ovr_cnt", n_ovr - ovr0, ovr ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, c0, cnt, guard;
    model_reset();
    do_reset();
    chk("rst_x", pacman_x, 310);
    chk("rst_y", pacman_y, 230);
    chk("rst_dir", curDir, 3);
    chk("rst_req", chkReq, 0);
    chk("rst_cx", chkX, 0);
    chk("rst_cy", chkY, 0);
    chk("rst_mov", moving, 0);
    chk("rst_md", moveDone, 0);
    chk("rst_ovr", frameOverrun, 0);

    // three straight frames heading right
    d0 = n_done;
    repeat (3) frame(0, 0, 2, 0);
    chk("f3_x", pacman_x, 313);
    chk("f3_y", pacman_y, 230);
    chk("f3_done", n_done - d0, 3);

    // restart from start position for the turn scenario
    do_reset();
    set_btn(4'b1000);
    set_btn(4'b0000);
    frame(1, 0, 1, 0);          // up blocked, straight commits
    chk("turn_x", pacman_x, 311);
    chk("turn_dir", curDir, 3);
    frame(0, 0, 0, 0);          // buffered up turn now succeeds
    chk("turn_y", pacman_y, 229);
    chk("turn_dir2", curDir, 0);
    chk("turn_mov", moving, 1);

    // left and right together: left wins
    set_btn(4'b0011);
    set_btn(4'b0000);
    frame(0, 0, 1, 0);
    chk("lr_dir", curDir, 2);

    // second edge during the straight query
    c0 = n_commit;
    frame(0, 0, 3, 1);
    chk("one_commit", n_commit - c0, 1);

    // run to the right edge and sit against it
    set_btn(4'b0001);
    guard = 0;
    while (m_x < MX && guard < 700) begin frame(0, 0, 0, 0); guard++; end
    set_btn(4'b0000);
    frame(0, 0, 0, 0);
    frame(0, 0, 1, 0);
    chk("edge_x", pacman_x, MX);
    chk("edge_mov", moving, 0);

    // reset while a turn query is outstanding
    do_reset();
    set_btn(4'b1000);
    set_btn(4'b0000);
    screenEnd = 1'b1;
    @(negedge clk);
    screenEnd = 1'b0;
    cnt = 0;
    while (!chkReq && cnt < 10) begin @(negedge clk); cnt++; end
    chk("r_wait", chkReq, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chkAck = 1'b1;
    chkBlocked = 1'b0;
    chk("r_req0", chkReq, 0);
    d0 = n_done;
    @(negedge clk);
    chkAck = 1'b0;
    repeat (5) begin chk("r_noreq", chkReq, 0); @(negedge clk); end
    chk("r_x", pacman_x, 310);
    chk("r_y", pacman_y, 230);
    chk("r_nodone", n_done - d0, 0);
    model_reset();

    // random frames
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 9) < 3) set_btn(4'($urandom_range(1, 15)));
      else set_btn(4'b0000);
      frame($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pacman_motion_ctrl.md
PACMAN_MOTION_CTRL -- requirements
Module: pacman_motion_ctrl

Interface
REQ-001 Parameter START_X, default 310: pacman_x reset value.
REQ-002 Parameter START_Y, default 230: pacman_y reset value.
REQ-003 Parameter MAX_X, default 618: largest legal pacman_x (640-22).
REQ-004 Parameter MAX_Y, default 458: largest legal pacman_y (480-22).
REQ-005 clk  in  1  100 MHz system clock; the block has one clock domain.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 screenEnd  in  1  frame-boundary level from the VGA timing generator; only its rising edge is used.
REQ-008 BTNU, BTND, BTNL, BTNR  in  1 each  raw direction buttons.
REQ-009 chkAck  in  1  one-cycle pulse; the wall checker has finished the current query.
REQ-010 chkBlocked  in  1  wall-check result; valid only while chkAck=1.
REQ-011 chkReq  out  1  wall-check query valid.
REQ-012 chkX  out  10  candidate x position under query.
REQ-013 chkY  out  9  candidate y position under query.
REQ-014 pacman_x  out  10  committed sprite x; this is the position consumed by the VGA renderer.
REQ-015 pacman_y  out  9  committed sprite y.
REQ-016 curDir  out  2  current heading: 0=up, 1=down, 2=left, 3=right.
REQ-017 moving  out  1  last frame produced a committed step.
REQ-018 moveDone  out  1  one-cycle pulse when frame processing ends.
REQ-019 frameOverrun  out  1  one-cycle pulse when a frame edge is dropped.

Function
REQ-020 Each button passes through a 2-flop synchronizer; all decisions use the synchronized values.
REQ-021 Requested direction: any synchronized button high loads reqDir and sets reqValid=1.
REQ-022 reqDir priority when several buttons are high is U > D > L > R.
REQ-023 reqValid remains set until reset, so the requested turn stays buffered.
REQ-024 Frame edge: screenEnd is registered once; frameTick = screenEnd & ~screenEnd_q.
REQ-025 FSM states are IDLE, TRY_REQ, WAIT_REQ, TRY_CUR, WAIT_CUR and DONE.
REQ-026 IDLE + frameTick: go to TRY_REQ if reqValid=1 and reqDir!=curDir; otherwise go to TRY_CUR.
REQ-027 Candidate position is the committed position stepped by 1 pixel in the tried direction: up y-1, down y+1, left x-1, right x+1.
REQ-028 Candidate outside 0..MAX_X or 0..MAX_Y: treat as blocked in the same TRY state, with no query issued. No wrap-around.
REQ-029 TRY_* with an in-range candidate: drive chkX/chkY, assert chkReq, then enter WAIT_*.
REQ-030 chkReq, chkX and chkY hold stable from assertion through the chkAck cycle.
REQ-031 chkReq drops in the cycle after chkAck.
REQ-032 chkAck is ignored outside WAIT_*.
REQ-033 WAIT_REQ + chkAck + !chkBlocked: commit the candidate to pacman_x/y, set curDir=reqDir, set moving=1, go to DONE.
REQ-034 WAIT_REQ + chkAck + chkBlocked: go to TRY_CUR; heading is unchanged.
REQ-035 WAIT_CUR + chkAck + !chkBlocked: commit the candidate, set moving=1, go to DONE.
REQ-036 WAIT_CUR + chkAck + chkBlocked, or a TRY_CUR out-of-range candidate: moving=0, position unchanged, go to DONE.
REQ-037 DONE: pulse moveDone for 1 cycle, then return to IDLE.
REQ-038 Maximum latency from frameTick to moveDone, excluding checker wait, is 5 cycles.
REQ-039 frameTick in any state other than IDLE: the edge is dropped, frameOverrun pulses, and the FSM continues unaffected.
REQ-040 pacman_x/y change only in the commit cycle; they are never changed mid-query.
REQ-041 All arithmetic is unsigned at port width. Underflow is prevented solely by the range check in REQ-028.

Reset
REQ-042 On reset: pacman_x=START_X, pacman_y=START_Y, curDir=3, reqValid=0, moving=0.
REQ-043 On reset: chkReq=0, chkX=0, chkY=0, moveDone=0, frameOverrun=0, synchronizers and screenEnd_q cleared, FSM=IDLE.
REQ-044 Reset asserted mid-query overrides all states. The next cycle has chkReq=0, and a chkAck arriving afterward is ignored.

Verification
REQ-045 Reset, no buttons, 3 frame edges, checker always acks unblocked after 2 cycles -> pacman_x 310->313, y=230, curDir=3, 3 moveDone pulses.
REQ-046 From (310,230) heading right, press BTNU 1 frame, first query (310,229) acked blocked -> second query (311,230); commit x=311, curDir=3, reqValid stays 1.
REQ-047 Next frame with the up query unblocked -> y=229, curDir=0, moving=1.
REQ-048 pacman_x=618 heading right, no turn buffered, frame edge -> chkReq never asserted, moving=0, x stays 618, moveDone pulses.
REQ-049 BTNL and BTNR held together -> reqDir=2 (left).
REQ-050 Second frame edge while in WAIT_CUR -> one frameOverrun pulse and exactly one commit.
REQ-051 Reset asserted during WAIT_REQ, chkAck next cycle -> position (310,230), chkReq=0, no commit.
